vec_wb_stage: RTL and testbench
===============================

VEC_WB_STAGE -- requirements
Module: vec_wb_stage

Interface
REQ-001 SHALL have parameter VLEN, default 8, elements per vector.
REQ-002 SHALL have parameter EWIDTH, default 32, element width in bits.
REQ-003 SHALL have parameter LANES, default 2, elements written per register-file beat; VLEN divisible by LANES.
REQ-004 SHALL have parameter DEPTH, default 2, result buffer entries.
REQ-005 SHALL have port clk input 1 clock; all state on rising edge.
REQ-006 SHALL have port rst_n input 1 reset, asynchronous, active-low.
REQ-007 SHALL have port ex_done input 1 one-cycle pulse: execute result valid.
REQ-008 SHALL have port ex_result input EWIDTH*VLEN full vector result; element i at bits [i*EWIDTH +: EWIDTH].
REQ-009 SHALL have port ex_vd input 5 destination vector register.
REQ-010 SHALL have port wb_full output 1 buffer full; upstream holds execute issue.
REQ-011 SHALL have port rf_we output 1 register-file write request.
REQ-012 SHALL have port rf_wready input 1 register file accepts current beat.
REQ-013 SHALL have port rf_waddr output 5 destination register of current beat.
REQ-014 SHALL have port rf_wbeat output clog2(VLEN/LANES) beat index.
REQ-015 SHALL have port rf_wdata output EWIDTH*LANES beat data.
REQ-016 SHALL have port wb_done output 1 one-cycle pulse: vector fully written.
REQ-017 SHALL have port wb_vd output 5 register completed (scoreboard clear), valid with wb_done.
REQ-018 SHALL have port ovf_err output 1 sticky: ex_done arrived while full.

Function
REQ-019 SHALL push {ex_vd, ex_result} into a DEPTH-entry FIFO on the edge ending any cycle where ex_done=1 and wb_full=0.
REQ-020 SHALL drive wb_full=1 exactly when registered occupancy equals DEPTH.
REQ-021 SHALL, on ex_done while full, discard the result, keep FIFO unchanged, set ovf_err=1.
REQ-022 SHALL implement FSM IDLE/WRITE; IDLE->WRITE when FIFO non-empty; WRITE->IDLE after last beat accepted with FIFO then empty.
REQ-023 SHALL in WRITE assert rf_we=1 with rf_waddr=head vd, rf_wbeat=b, rf_wdata=head bits [b*LANES*EWIDTH +: LANES*EWIDTH].
REQ-024 SHALL hold rf_we, rf_waddr, rf_wbeat, rf_wdata stable while rf_we=1 and rf_wready=0.
REQ-025 SHALL advance b on each cycle with rf_we=1 and rf_wready=1; beats = VLEN/LANES.
REQ-026 SHALL on acceptance of last beat pop head, reset b to 0, and pulse wb_done=1 with wb_vd=popped vd in the next cycle.
REQ-027 SHALL, if another entry remains (or is pushed the same edge), start its beat 0 in the next cycle with no idle bubble.
REQ-028 SHALL allow simultaneous push and pop; occupancy unchanged; push on full-with-pop-same-cycle still refused (wb_full registered).
REQ-029 SHALL produce first rf_we one cycle after the ex_done cycle when IDLE and empty.
REQ-030 SHALL drive rf_we=0 in IDLE; rf_wdata/rf_waddr don't-care then but driven zero.

Reset
REQ-031 SHALL on rst_n=0 clear FIFO pointers/occupancy, b, FSM=IDLE, wb_full=0, rf_we=0, rf_wbeat=0, rf_waddr=0, rf_wdata=0, wb_done=0, wb_vd=0, ovf_err=0.
REQ-032 SHALL discard all buffered and partially written results on reset mid-operation; no wb_done for them.

Structure
REQ-033 SHALL place FSM state encoding and VREG_AW=5 in the shared vector package.
REQ-034 SHALL use one sub-module, vec_result_fifo (parameterised width/DEPTH, push/pop/full/empty); beat sequencing stays in vec_wb_stage.

Verification
REQ-035 SHALL cover: single ex_done, vd=3, elements 0..7=0x10..0x17, rf_wready=1 -> beats 0..3 data {0x11,0x10},{0x13,0x12},{0x15,0x14},{0x17,0x16} in cycles N+1..N+4; wb_done, wb_vd=3 at N+5.
REQ-036 SHALL cover: rf_wready=0 for 3 cycles on beat 1 -> outputs held, beat 1 repeated, wb_done delayed by 3 cycles.
REQ-037 SHALL cover: three ex_done pulses, rf_wready=0 -> first two buffered, wb_full=1, third dropped, ovf_err=1; release -> vd1 then vd2 written back-to-back, 8 beats contiguous.
REQ-038 SHALL cover: ex_done coincident with last-beat acceptance -> push and pop same edge, next vector beat 0 in next cycle.
REQ-039 SHALL cover: rst_n low during beat 2 -> all outputs zero asynchronously, no wb_done after release, next ex_done handled normally.

Source files
------------

// File: rtl/vec_wb_stage_pkg.sv
// Shared definitions for the vector writeback stage: register address width
// and the writeback sequencer state encoding.
package vec_wb_stage_pkg;

    // Vector register file has 32 architectural registers.
    localparam int unsigned VREG_AW = 5;

    typedef enum logic {
        StIdle,
        StWrite
    } wb_state_e;

endpackage

// File: rtl/vec_result_fifo.sv
// Small circular FIFO holding completed execute results awaiting writeback.
// Occupancy is registered so full/empty never depend on same-cycle push/pop.
module vec_result_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Storage array; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/vec_wb_stage.sv
// Vector writeback stage: buffers full-vector execute results and streams
// each one into the register file LANES elements per beat, then reports the
// completed destination register for scoreboard release.
module vec_wb_stage
    import vec_wb_stage_pkg::*;
#(
    parameter int unsigned VLEN   = 8,
    parameter int unsigned EWIDTH = 32,
    parameter int unsigned LANES  = 2,
    parameter int unsigned DEPTH  = 2,
    localparam int unsigned BEAT_W = (VLEN / LANES > 1) ? $clog2(VLEN / LANES) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_done,
    input  logic [EWIDTH*VLEN-1:0]    ex_result,
    input  logic [VREG_AW-1:0]        ex_vd,
    output logic                      wb_full,
    output logic                      rf_we,
    input  logic                      rf_wready,
    output logic [VREG_AW-1:0]        rf_waddr,
    output logic [BEAT_W-1:0]         rf_wbeat,
    output logic [EWIDTH*LANES-1:0]   rf_wdata,
    output logic                      wb_done,
    output logic [VREG_AW-1:0]        wb_vd,
    output logic                      ovf_err
);

    localparam int unsigned BEATS   = VLEN / LANES;
    localparam int unsigned BEAT_DW = EWIDTH * LANES;
    localparam int unsigned VEC_W   = EWIDTH * VLEN;
    localparam int unsigned ENT_W   = VREG_AW + VEC_W;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    wb_state_e          state_q;
    logic [BEAT_W-1:0]  beat_q;
    logic               wb_done_q;
    logic [VREG_AW-1:0] wb_vd_q;
    logic               ovf_err_q;

    logic               push;
    logic               pop;
    logic [ENT_W-1:0]   head;
    logic [VREG_AW-1:0] head_vd;
    logic [VEC_W-1:0]   head_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               accept;
    logic               last_beat;
    logic               more_after_pop;
    logic [BEAT_DW-1:0] beat_data;

    vec_result_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({ex_vd, ex_result}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign head_vd   = head[ENT_W-1 -: VREG_AW];
    assign head_data = head[VEC_W-1:0];

    // Full is the registered occupancy, so a push is refused even when the
    // head pops on the same edge.
    assign push      = ex_done && !fifo_full;
    assign accept    = (state_q == StWrite) && rf_wready;
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
    assign pop       = accept && last_beat;
    // Another vector is ready right after this pop: either already queued
    // behind the head or arriving on the same edge.
    assign more_after_pop = (fifo_cnt > CNT_W'(1)) || push;

    // Select the LANES-element slice of the head vector for the current beat.
    always_comb begin
        beat_data = '0;
        for (int unsigned i = 0; i < BEATS; i++) begin
            if (beat_q == BEAT_W'(i)) begin
                beat_data = head_data[i*BEAT_DW +: BEAT_DW];
            end
        end
    end

    // Writeback sequencer: beat counter, completion pulse and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            wb_done_q <= 1'b0;
            wb_vd_q   <= '0;
            ovf_err_q <= 1'b0;
        end else begin
            wb_done_q <= 1'b0;
            if (ex_done && fifo_full) begin
                ovf_err_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    beat_q <= '0;
                    // Entering on the push edge gives beat 0 the very next cycle.
                    if (push || !fifo_empty) begin
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    if (accept) begin
                        if (last_beat) begin
                            beat_q    <= '0;
                            wb_done_q <= 1'b1;
                            wb_vd_q   <= head_vd;
                            if (!more_after_pop) begin
                                state_q <= StIdle;
                            end
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    beat_q  <= '0;
                end
            endcase
        end
    end

    // Beat outputs come straight from registered state; zeroed while idle.
    always_comb begin
        rf_we    = (state_q == StWrite);
        rf_waddr = rf_we ? head_vd : '0;
        rf_wbeat = rf_we ? beat_q : '0;
        rf_wdata = rf_we ? beat_data : '0;
    end

    assign wb_full = fifo_full;
    assign wb_done = wb_done_q;
    assign wb_vd   = wb_vd_q;
    assign ovf_err = ovf_err_q;

endmodule

// File: tb/tb_vec_wb_stage.sv
// Self-checking bench for vec_wb_stage: a queue-based model of pending
// vectors predicts every output each cycle, and directed scenarios pin a few
// hand-computed values.
module tb_vec_wb_stage;

    localparam int unsigned VLEN   = 8;
    localparam int unsigned EWIDTH = 32;
    localparam int unsigned LANES  = 2;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned BEATS  = VLEN / LANES;
    localparam int unsigned BDW    = EWIDTH * LANES;

    logic                   clk;
    logic                   rst_n;
    logic                   ex_done;
    logic [EWIDTH*VLEN-1:0] ex_result;
    logic [4:0]             ex_vd;
    logic                   wb_full;
    logic                   rf_we;
    logic                   rf_wready;
    logic [4:0]             rf_waddr;
    logic [1:0]             rf_wbeat;
    logic [BDW-1:0]         rf_wdata;
    logic                   wb_done;
    logic [4:0]             wb_vd;
    logic                   ovf_err;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    vec_wb_stage #(
        .VLEN   (VLEN),
        .EWIDTH (EWIDTH),
        .LANES  (LANES),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_done   (ex_done),
        .ex_result (ex_result),
        .ex_vd     (ex_vd),
        .wb_full   (wb_full),
        .rf_we     (rf_we),
        .rf_wready (rf_wready),
        .rf_waddr  (rf_waddr),
        .rf_wbeat  (rf_wbeat),
        .rf_wdata  (rf_wdata),
        .wb_done   (wb_done),
        .wb_vd     (wb_vd),
        .ovf_err   (ovf_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [4:0]             vd;
        logic [EWIDTH*VLEN-1:0] data;
    } ent_t;

    ent_t       mq[$];
    int         m_beat = 0;
    bit         m_done = 0;
    logic [4:0] m_vd = '0;
    bit         m_ovf = 0;

    // A vector is being written whenever any result is pending; the buffer is
    // full when DEPTH results are pending at the start of the cycle.
    always @(posedge clk or negedge rst_n) begin : model
        bit was_full;
        if (!rst_n) begin
            mq.delete();
            m_beat = 0;
            m_done = 0;
            m_vd   = '0;
            m_ovf  = 0;
        end else begin
            was_full = (mq.size() == DEPTH);
            m_done = 0;
            if (mq.size() > 0 && rf_wready) begin
                if (m_beat == BEATS - 1) begin
                    m_done = 1;
                    m_vd   = mq[0].vd;
                    void'(mq.pop_front());
                    m_beat = 0;
                end else begin
                    m_beat++;
                end
            end
            if (ex_done) begin
                if (was_full) m_ovf = 1;
                else          mq.push_back('{vd: ex_vd, data: ex_result});
            end
        end
    end

    // Compare every cycle against the model, away from the active edge.
    always @(negedge clk) begin : compare
        logic [BDW-1:0] e_data;
        logic [4:0]     e_addr;
        bit             e_we;
        if (started) begin
            e_we   = (mq.size() > 0);
            e_data = '0;
            e_addr = '0;
            if (e_we) begin
                e_data = mq[0].data[m_beat*BDW +: BDW];
                e_addr = mq[0].vd;
            end
            chk("m_rf_we", 64'(rf_we), 64'(e_we));
            chk("m_rf_waddr", 64'(rf_waddr), 64'(e_addr));
            chk("m_rf_wbeat", 64'(rf_wbeat), e_we ? 64'(m_beat) : 64'd0);
            chk("m_rf_wdata", 64'(rf_wdata), 64'(e_data));
            chk("m_wb_full", 64'(wb_full), 64'(mq.size() == DEPTH));
            chk("m_wb_done", 64'(wb_done), 64'(m_done));
            if (m_done) chk("m_wb_vd", 64'(wb_vd), 64'(m_vd));
            chk("m_ovf_err", 64'(ovf_err), 64'(m_ovf));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [EWIDTH*VLEN-1:0] mkvec(input int base);
        logic [EWIDTH*VLEN-1:0] v;
        for (int i = 0; i < VLEN; i++) v[i*EWIDTH +: EWIDTH] = 32'(base + i);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [4:0] vd, input int base);
        ex_done   = 1'b1;
        ex_vd     = vd;
        ex_result = mkvec(base);
        step();
        ex_done   = 1'b0;
    endtask

    logic [63:0] s1_beats [4];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        s1_beats[0] = 64'h00000011_00000010;
        s1_beats[1] = 64'h00000013_00000012;
        s1_beats[2] = 64'h00000015_00000014;
        s1_beats[3] = 64'h00000017_00000016;

        rst_n     = 1'b1;
        ex_done   = 1'b0;
        ex_vd     = '0;
        ex_result = '0;
        rf_wready = 1'b1;
        #3 rst_n  = 1'b0;
        started   = 1;

        // Reset state
        @(negedge clk);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_wb_full", 64'(wb_full), 64'd0);
        chk("rst_ovf_err", 64'(ovf_err), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single vector, no backpressure: beats N+1..N+4, done at N+5
        pulse(5'd3, 'h10);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("s1_we", 64'(rf_we), 64'd1);
            chk("s1_beat", 64'(rf_wbeat), 64'(k));
            chk("s1_data", 64'(rf_wdata), s1_beats[k]);
            step();
        end
        @(negedge clk);
        chk("s1_done", 64'(wb_done), 64'd1);
        chk("s1_vd", 64'(wb_vd), 64'd3);
        step();
        step();

        // Three-cycle stall on beat 1
        pulse(5'd5, 'h20);
        step();
        rf_wready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("s2_hold_beat", 64'(rf_wbeat), 64'd1);
            chk("s2_hold_data", 64'(rf_wdata), 64'h00000023_00000022);
            step();
        end
        rf_wready = 1'b1;
        step();
        step();
        step();
        @(negedge clk);
        chk("s2_done", 64'(wb_done), 64'd1);
        chk("s2_vd", 64'(wb_vd), 64'd5);
        step();
        step();

        // Overflow: two buffered, third dropped, then back-to-back drain
        rf_wready = 1'b0;
        pulse(5'd1, 'h30);
        pulse(5'd2, 'h40);
        pulse(5'd4, 'h50);
        rf_wready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("s3_full", 64'(wb_full), 64'd1);
                chk("s3_ovf", 64'(ovf_err), 64'd1);
            end
            if (k == 4) begin
                chk("s3_done1", 64'(wb_done), 64'd1);
                chk("s3_vd1", 64'(wb_vd), 64'd1);
            end
            chk("s3_we", 64'(rf_we), 64'd1);
            chk("s3_addr", 64'(rf_waddr), (k < 4) ? 64'd1 : 64'd2);
            chk("s3_beat", 64'(rf_wbeat), 64'(k % 4));
            step();
        end
        @(negedge clk);
        chk("s3_done2", 64'(wb_done), 64'd1);
        chk("s3_vd2", 64'(wb_vd), 64'd2);
        step();
        step();

        // Push coincident with last-beat pop: no bubble
        pulse(5'd6, 'h60);
        step();
        step();
        step();
        pulse(5'd7, 'h70);
        @(negedge clk);
        chk("s4_we", 64'(rf_we), 64'd1);
        chk("s4_addr", 64'(rf_waddr), 64'd7);
        chk("s4_beat", 64'(rf_wbeat), 64'd0);
        chk("s4_data", 64'(rf_wdata), 64'h00000071_00000070);
        chk("s4_done", 64'(wb_done), 64'd1);
        chk("s4_vd", 64'(wb_vd), 64'd6);
        for (int k = 0; k < 5; k++) step();

        // Asynchronous reset during beat 2
        pulse(5'd9, 'h90);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("s5_we", 64'(rf_we), 64'd0);
        chk("s5_addr", 64'(rf_waddr), 64'd0);
        chk("s5_beat", 64'(rf_wbeat), 64'd0);
        chk("s5_data", 64'(rf_wdata), 64'd0);
        chk("s5_full", 64'(wb_full), 64'd0);
        chk("s5_done", 64'(wb_done), 64'd0);
        chk("s5_vd", 64'(wb_vd), 64'd0);
        chk("s5_ovf", 64'(ovf_err), 64'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("s5_no_done", 64'(wb_done), 64'd0);
            step();
        end
        pulse(5'd10, 'hA0);
        @(negedge clk);
        chk("s5_next_data", 64'(rf_wdata), 64'h000000A1_000000A0);
        step();
        step();
        step();
        step();
        @(negedge clk);
        chk("s5_next_done", 64'(wb_done), 64'd1);
        chk("s5_next_vd", 64'(wb_vd), 64'd10);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
